ipm_core_fifo_proc: RTL and testbench

//  IP-side processing core; sits directly downstream of the MCU register interface and consumes its
//  32-bit data word, 5-bit config and single-cycle read/write/start pulses. Write pulses queue words in
//  an input FIFO; a start pulse processes the queued batch per config opcode into an output FIFO.
//  The output FIFO head drives dataOutIPo (first-word-fall-through); the register block captures it on readIPi.

---
 rtl/ipm_core_pkg.sv | 23 ++
 rtl/ipm_sync_fifo.sv | 57 +++++
 rtl/ipm_core_fifo_proc.sv | 172 +++++++++++++++++
 tb/tb_ipm_core_fifo_proc.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/ipm_core_pkg.sv
// Shared opcodes, FSM states and status bit positions for the IPM processing core.
package ipm_core_pkg;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_SUM  = 3'd1;
  localparam logic [2:0] OP_SWAP = 3'd2;
  localparam logic [2:0] OP_INV  = 3'd3;
  localparam logic [2:0] OP_INC  = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_PUSH,
    ST_DONE
  } state_t;

  localparam int unsigned STAT_IN_EMPTY  = 0;
  localparam int unsigned STAT_IN_FULL   = 1;
  localparam int unsigned STAT_OUT_EMPTY = 2;
  localparam int unsigned STAT_OUT_FULL  = 3;
  localparam int unsigned STAT_OVF       = 4;

endpackage

// File: rtl/ipm_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head (reads 0 when empty) and flush.
module ipm_sync_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  clk_n_Hz,
  input  logic                  rst_async_low,
  input  logic                  clear,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_W:0]       count
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]     wrPtr;
  logic [ADDR_W-1:0]     rdPtr;
  logic                  doPush;
  logic                  doPop;

  assign full   = (count == (ADDR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  // Pop on empty is ignored; push on full only lands when a pop frees the slot.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);
  assign head   = empty ? '0 : mem[rdPtr];

  always_ff @(posedge clk_n_Hz) begin
    if (doPush && !clear) mem[wrPtr] <= din;
  end

  always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
    if (!rst_async_low) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (clear) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + ADDR_W'(1);
      if (doPop)  rdPtr <= rdPtr + ADDR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ipm_core_fifo_proc.sv
// IP-side processing core: queues words, processes a latched batch per opcode into an output FIFO.
module ipm_core_fifo_proc
  import ipm_core_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CONF_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 3
) (
  input  logic                  clk_n_Hz,
  input  logic                  rst_async_low,
  input  logic [DATA_WIDTH-1:0] dataInIPi,
  input  logic [CONF_WIDTH-1:0] configIPi,
  input  logic                  writeIPi,
  input  logic                  readIPi,
  input  logic                  startIPi,
  output logic [DATA_WIDTH-1:0] dataOutIPo,
  output logic                  busyIPo,
  output logic                  doneIPo,
  output logic [4:0]            statusIPo
);

  state_t                state, stateNext;
  logic [ADDR_W:0]       n, nNext;
  logic [DATA_WIDTH-1:0] acc, accNext;
  logic [DATA_WIDTH-1:0] result, resultNext;
  logic [2:0]            opLat, opNext;
  logic                  satLat, satNext;
  logic                  ovf;

  logic                  softClr;
  logic                  inPop, outPush;
  logic [DATA_WIDTH-1:0] inHead;
  logic                  inFull, inEmpty;
  logic [ADDR_W:0]       inCount;
  logic                  outFull, outEmpty;
  logic [ADDR_W:0]       outCount;
  logic [DATA_WIDTH:0]   sumWide;
  logic [DATA_WIDTH-1:0] swapped;

  assign softClr = configIPi[4];

  ipm_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) uInFifo (
    .clk_n_Hz      (clk_n_Hz),
    .rst_async_low (rst_async_low),
    .clear         (softClr),
    .push          (writeIPi),
    .pop           (inPop),
    .din           (dataInIPi),
    .head          (inHead),
    .full          (inFull),
    .empty         (inEmpty),
    .count         (inCount)
  );

  ipm_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .ADDR_W(ADDR_W)) uOutFifo (
    .clk_n_Hz      (clk_n_Hz),
    .rst_async_low (rst_async_low),
    .clear         (softClr),
    .push          (outPush),
    .pop           (readIPi),
    .din           (result),
    .head          (dataOutIPo),
    .full          (outFull),
    .empty         (outEmpty),
    .count         (outCount)
  );

  assign sumWide = {1'b0, acc} + {1'b0, inHead};

  always_comb begin
    swapped = '0;
    for (int unsigned b = 0; b < DATA_WIDTH / 8; b++)
      swapped[b*8 +: 8] = inHead[(DATA_WIDTH/8 - 1 - b)*8 +: 8];
  end

  always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
    if (!rst_async_low) begin
      state  <= ST_IDLE;
      n      <= '0;
      acc    <= '0;
      result <= '0;
      opLat  <= OP_PASS;
      satLat <= 1'b0;
    end else begin
      state  <= stateNext;
      n      <= nNext;
      acc    <= accNext;
      result <= resultNext;
      opLat  <= opNext;
      satLat <= satNext;
    end
  end

  always_comb begin
    stateNext  = state;
    nNext      = n;
    accNext    = acc;
    resultNext = result;
    opNext     = opLat;
    satNext    = satLat;
    inPop      = 1'b0;
    outPush    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (startIPi) begin
          nNext     = inCount;
          accNext   = '0;
          opNext    = configIPi[2:0];
          satNext   = configIPi[3];
          stateNext = (inCount != '0) ? ST_POP : ST_DONE;
        end
      end
      ST_POP: begin
        inPop = 1'b1;
        nNext = n - (ADDR_W+1)'(1);
        if (opLat == OP_SUM) begin
          accNext    = (satLat && sumWide[DATA_WIDTH]) ? '1 : sumWide[DATA_WIDTH-1:0];
          resultNext = accNext;
          stateNext  = (n > (ADDR_W+1)'(1)) ? ST_POP : ST_PUSH;
        end else begin
          case (opLat)
            OP_SWAP: resultNext = swapped;
            OP_INV:  resultNext = ~inHead;
            OP_INC:  resultNext = inHead + DATA_WIDTH'(1);
            default: resultNext = inHead;
          endcase
          stateNext = ST_PUSH;
        end
      end
      ST_PUSH: begin
        if (outCount < (ADDR_W+1)'(FIFO_DEPTH)) begin
          outPush   = 1'b1;
          stateNext = (n != '0) ? ST_POP : ST_DONE;
        end
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
    // Soft clear is a level: it pins the core idle for as long as it is held.
    if (softClr) begin
      stateNext = ST_IDLE;
      accNext   = '0;
      inPop     = 1'b0;
      outPush   = 1'b0;
    end
  end

  always_ff @(posedge clk_n_Hz or negedge rst_async_low) begin
    if (!rst_async_low)
      ovf <= 1'b0;
    else if (softClr)
      ovf <= 1'b0;
    else if (writeIPi && inFull && !inPop)
      ovf <= 1'b1;
    else if (startIPi && state == ST_IDLE)
      ovf <= 1'b0;
  end

  assign busyIPo = (state != ST_IDLE);
  assign doneIPo = (state == ST_DONE) && !softClr;

  always_comb begin
    statusIPo                 = '0;
    statusIPo[STAT_OVF]       = ovf;
    statusIPo[STAT_OUT_FULL]  = outFull;
    statusIPo[STAT_OUT_EMPTY] = outEmpty;
    statusIPo[STAT_IN_FULL]   = inFull;
    statusIPo[STAT_IN_EMPTY]  = inEmpty;
  end

endmodule

// File: tb/tb_ipm_core_fifo_proc.sv
// Directed testbench for ipm_core_fifo_proc with hand-computed expectations.
module tb_ipm_core_fifo_proc;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] dataIn = '0;
  logic [4:0]  cfg = '0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dataOut;
  logic        busy;
  logic        done;
  logic [4:0]  status;

  int checks = 0;
  int errors = 0;
  int dc;

  ipm_core_fifo_proc #(.DATA_WIDTH(32), .CONF_WIDTH(5), .FIFO_DEPTH(8), .ADDR_W(3)) dut (
    .clk_n_Hz      (clk),
    .rst_async_low (rst),
    .dataInIPi     (dataIn),
    .configIPi     (cfg),
    .writeIPi      (wr),
    .readIPi       (rd),
    .startIPi      (start),
    .dataOutIPo    (dataOut),
    .busyIPo       (busy),
    .doneIPo       (done),
    .statusIPo     (status)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic writeWord(input logic [31:0] d);
    dataIn = d;
    wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic readPulse();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count done pulses until the core goes idle, bounded.
  task automatic runBatch(output int cnt);
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (done) cnt++;
      if (!busy) break;
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    check("rst_status", status, 5'b00101);
    check("rst_data", dataOut, 32'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst = 1'b1;
    @(negedge clk);

    // 1: pass-through of three words
    cfg = 5'd0;
    writeWord(32'h11);
    writeWord(32'h22);
    writeWord(32'h33);
    check("t1_status_loaded", status, 5'b00100);
    startPulse();
    check("t1_busy", busy, 1'b1);
    runBatch(dc);
    check("t1_done_cnt", dc, 1);
    check("t1_idle", busy, 1'b0);
    check("t1_r0", dataOut, 32'h11);
    readPulse();
    check("t1_r1", dataOut, 32'h22);
    readPulse();
    check("t1_r2", dataOut, 32'h33);
    readPulse();
    check("t1_empty_data", dataOut, 32'h0);
    check("t1_empty_status", status, 5'b00101);
    readPulse();
    check("t1_read_empty", status, 5'b00101);

    // 2: sum wrap and saturate
    cfg = 5'd1;
    writeWord(32'hFFFF_FFFF);
    writeWord(32'h2);
    startPulse();
    runBatch(dc);
    check("t2_done_cnt", dc, 1);
    check("t2_sum_wrap", dataOut, 32'h0000_0001);
    readPulse();
    check("t2_single_result", status, 5'b00101);
    cfg = 5'd9;
    writeWord(32'hFFFF_FFFF);
    writeWord(32'h2);
    startPulse();
    runBatch(dc);
    check("t2_sum_sat", dataOut, 32'hFFFF_FFFF);
    readPulse();

    // 3: byte swap with latency check, invert, increment wrap
    cfg = 5'd2;
    writeWord(32'h1234_5678);
    startPulse();
    @(negedge clk);
    check("t3_lat_pop", dataOut, 32'h0);
    @(negedge clk);
    check("t3_swap", dataOut, 32'h7856_3412);
    runBatch(dc);
    check("t3_done_cnt", dc, 1);
    readPulse();
    cfg = 5'd3;
    writeWord(32'h0F0F_0000);
    startPulse();
    runBatch(dc);
    check("t3_inv", dataOut, 32'hF0F0_FFFF);
    readPulse();
    cfg = 5'd4;
    writeWord(32'hFFFF_FFFF);
    writeWord(32'h41);
    startPulse();
    runBatch(dc);
    check("t3_inc_wrap", dataOut, 32'h0);
    readPulse();
    check("t3_inc", dataOut, 32'h42);
    readPulse();

    // 4: overflow of the input FIFO
    cfg = 5'd0;
    for (int i = 1; i <= 9; i++) writeWord(32'h100 + i);
    check("t4_ovf_status", status, 5'b10110);
    startPulse();
    check("t4_ovf_cleared", status, 5'b00110);
    runBatch(dc);
    check("t4_done_cnt", dc, 1);
    check("t4_out_full", status, 5'b01001);
    check("t4_head", dataOut, 32'h101);

    // 5: output-full stall
    writeWord(32'hA);
    writeWord(32'hB);
    startPulse();
    repeat (6) @(negedge clk);
    check("t5_stall_busy", busy, 1'b1);
    check("t5_stall_status", status, 5'b01000);
    readPulse();
    check("t5_head_after_read", dataOut, 32'h102);
    repeat (6) @(negedge clk);
    check("t5_stall2_busy", busy, 1'b1);
    check("t5_stall2_status", status, 5'b01001);
    readPulse();
    runBatch(dc);
    check("t5_done_cnt", dc, 1);
    for (int i = 3; i <= 8; i++) begin
      check("t5_drain", dataOut, 32'h100 + i);
      readPulse();
    end
    check("t5_drain_a", dataOut, 32'hA);
    readPulse();
    check("t5_drain_b", dataOut, 32'hB);
    readPulse();
    check("t5_drained", status, 5'b00101);

    // 6: empty batch, soft clear mid-batch, async reset mid-batch
    startPulse();
    check("t6_empty_busy", busy, 1'b1);
    runBatch(dc);
    check("t6_empty_done", dc, 1);
    check("t6_empty_noout", status, 5'b00101);
    writeWord(32'h1);
    writeWord(32'h2);
    writeWord(32'h3);
    startPulse();
    @(negedge clk);
    cfg = 5'b10000;
    @(negedge clk);
    check("t6_clr_busy", busy, 1'b0);
    check("t6_clr_done", done, 1'b0);
    check("t6_clr_status", status, 5'b00101);
    check("t6_clr_data", dataOut, 32'h0);
    cfg = 5'd0;
    @(negedge clk);
    check("t6_clr_stays_idle", busy, 1'b0);
    writeWord(32'h5);
    writeWord(32'h6);
    startPulse();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_arst_busy", busy, 1'b0);
    check("t6_arst_status", status, 5'b00101);
    check("t6_arst_data", dataOut, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t6_arst_release", status, 5'b00101);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
